fetch_pc_unit: RTL and testbench

- Fetch stage directly upstream of the agree branch predictor.
- Holds the architectural fetch PC and drives the predictor's read-side indices and tag.
- Applies the predictor's next-PC select and flush to advance or redirect the PC.
- Runs a request/acknowledge handshake with instruction memory and fills the IF/ID register with the instruction plus its prediction metadata, which the pipeline carries to the commit stage.

---
 rtl/fetch_pkg.sv | 35 +++
 rtl/fetch_skid_reg.sv | 26 ++
 rtl/fetch_pc_unit.sv | 186 ++++++++++++++++++
 tb/tb_fetch_pc_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage: FSM states, next-PC select codes and the
// per-instruction record held by both the skid and IF/ID registers.
package fetch_pkg;

    // The ghr field is sized for the widest supported history; the top uses the low HISTORY_WIDTH bits.
    localparam int GHR_MAX_W = 32;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        SEL_PC4    = 2'b00,
        SEL_EX_PC4 = 2'b01,
        SEL_BTB    = 2'b10,
        SEL_EX_TGT = 2'b11
    } pcnext_sel_e;

    typedef struct packed {
        logic [31:0]          instr;
        logic [31:0]          pc;
        logic [31:0]          pc_plus4;
        logic                 prediction;
        logic                 btb_hit;
        logic                 bias;
        logic [GHR_MAX_W-1:0] ghr;
    } if_meta_t;

    function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_skid_reg.sv
// One-entry skid register holding an instruction and its prediction metadata
// while decode is stalled; clear has priority over load.
module fetch_skid_reg
    import fetch_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     load_i,
    input  logic     clear_i,
    input  if_meta_t d_i,
    output if_meta_t q_o
);

    if_meta_t skid_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            skid_q <= '0;
        end else if (load_i) begin
            skid_q <= d_i;
        end
    end

    assign q_o = skid_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC unit: owns the fetch PC, handshakes with instruction memory and fills IF/ID.
// Optional FETCH_PERF_CNT_EN adds saturating redirect and stall-cycle counters.
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter int          INDEX_WIDTH   = 6,
    parameter int          HISTORY_WIDTH = 8,
    parameter logic [31:0] RESET_PC      = 32'h0000_0000
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [1:0]                  IF_PCnext_sel_i,
    input  logic                        IF_flush_i,
    input  logic [31:0]                 IF_btb_rd_target_i,
    input  logic [31:0]                 EXMEM_pc_plus4_i,
    input  logic [31:0]                 EXMEM_br_target_i,
    input  logic                        IF_prediction_i,
    input  logic                        IF_btb_hit_i,
    input  logic                        IF_bias_i,
    input  logic [HISTORY_WIDTH-1:0]    IF_ghr_data_i,
    input  logic                        ID_stall_i,
    output logic                        imem_req_o,
    output logic [31:0]                 imem_addr_o,
    input  logic                        imem_ack_i,
    input  logic [31:0]                 imem_rdata_i,
    output logic [31:0]                 IF_pc_o,
    output logic [31-INDEX_WIDTH-2:0]   IF_PC_tag_o,
    output logic [INDEX_WIDTH-1:0]      IF_btb_rd_index_o,
    output logic [HISTORY_WIDTH-1:0]    IF_pht_rd_index_o,
    output logic                        IF_fire_o,
    output logic                        IFID_valid_o,
    output logic [31:0]                 IFID_instr_o,
    output logic [31:0]                 IFID_pc_o,
    output logic [31:0]                 IFID_pc_plus4_o,
    output logic                        IFID_prediction_o,
    output logic                        IFID_btb_hit_o,
    output logic                        IFID_bias_o,
    output logic [HISTORY_WIDTH-1:0]    IFID_ghr_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]                 perf_redirect_cnt_o,
    output logic [31:0]                 perf_stall_cnt_o
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    if_meta_t     ifid_q, ifid_d;
    logic         ifid_valid_q, ifid_valid_d;
    if_meta_t     fetch_meta, skid_meta;
    logic         skid_load, skid_clear;
    logic         fire;
    logic [31:0]  pc_target;

    always_comb begin
        fetch_meta                         = '0;
        fetch_meta.instr                   = imem_rdata_i;
        fetch_meta.pc                      = pc_q;
        fetch_meta.pc_plus4                = next_seq_pc(pc_q);
        fetch_meta.prediction              = IF_prediction_i;
        fetch_meta.btb_hit                 = IF_btb_hit_i;
        fetch_meta.bias                    = IF_bias_i;
        fetch_meta.ghr[HISTORY_WIDTH-1:0]  = IF_ghr_data_i;
    end

    always_comb begin
        pc_target = next_seq_pc(pc_q);
        case (pcnext_sel_e'(IF_PCnext_sel_i))
            SEL_PC4:    pc_target = next_seq_pc(pc_q);
            SEL_EX_PC4: pc_target = EXMEM_pc_plus4_i;
            SEL_BTB:    pc_target = IF_btb_rd_target_i;
            SEL_EX_TGT: pc_target = EXMEM_br_target_i;
            default:    pc_target = next_seq_pc(pc_q);
        endcase
    end

    always_comb begin
        fire = 1'b0;
        case (state_q)
            FETCH:   fire = imem_ack_i && !ID_stall_i && !IF_flush_i;
            HOLD:    fire = !ID_stall_i && !IF_flush_i;
            default: fire = 1'b0;
        endcase
        fire = fire && rst_ni;
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_d       = ifid_q;
        ifid_valid_d = ifid_valid_q;
        skid_load    = 1'b0;
        skid_clear   = 1'b0;
        if (IF_flush_i) begin
            pc_d         = pc_target;
            ifid_valid_d = 1'b0;
            skid_clear   = 1'b1;
            // Only an unacked request (fresh in FETCH or still pending in DRAIN) leaves a stale ack to drop.
            if ((state_q == FETCH || state_q == DRAIN) && !imem_ack_i) begin
                state_d = DRAIN;
            end else begin
                state_d = FETCH;
            end
        end else if (fire) begin
            pc_d         = pc_target;
            ifid_d       = (state_q == HOLD) ? skid_meta : fetch_meta;
            ifid_valid_d = 1'b1;
            state_d      = FETCH;
        end else begin
            if (!ID_stall_i) begin
                ifid_valid_d = 1'b0;
            end
            if (state_q == FETCH && imem_ack_i) begin
                skid_load = 1'b1;
                state_d   = HOLD;
            end else if (state_q == DRAIN && imem_ack_i) begin
                state_d = FETCH;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            ifid_q       <= '0;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_q       <= ifid_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    fetch_skid_reg u_skid (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .d_i     (fetch_meta),
        .q_o     (skid_meta)
    );

    assign imem_req_o        = rst_ni && (state_q == FETCH);
    assign imem_addr_o       = pc_q;
    assign IF_pc_o           = pc_q;
    assign IF_PC_tag_o       = pc_q[31:INDEX_WIDTH+2];
    assign IF_btb_rd_index_o = pc_q[INDEX_WIDTH+1:2];
    assign IF_pht_rd_index_o = pc_q[HISTORY_WIDTH+1:2];
    assign IF_fire_o         = fire;

    assign IFID_valid_o      = ifid_valid_q;
    assign IFID_instr_o      = ifid_q.instr;
    assign IFID_pc_o         = ifid_q.pc;
    assign IFID_pc_plus4_o   = ifid_q.pc_plus4;
    assign IFID_prediction_o = ifid_q.prediction;
    assign IFID_btb_hit_o    = ifid_q.btb_hit;
    assign IFID_bias_o       = ifid_q.bias;
    assign IFID_ghr_o        = ifid_q.ghr[HISTORY_WIDTH-1:0];

    logic unused_ghr;
    assign unused_ghr = ^ifid_q.ghr;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] redirect_cnt_q, stall_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            redirect_cnt_q <= '0;
            stall_cnt_q    <= '0;
        end else begin
            if (IF_flush_i && redirect_cnt_q != 32'hFFFF_FFFF) begin
                redirect_cnt_q <= redirect_cnt_q + 32'd1;
            end
            if ((state_q == HOLD || state_q == DRAIN) && stall_cnt_q != 32'hFFFF_FFFF) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign perf_redirect_cnt_o = redirect_cnt_q;
    assign perf_stall_cnt_o    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Testbench for fetch_pc_unit: directed scenarios then randomized traffic, all
// compared against a transaction-level reference model of the fetch stage.
module tb_fetch_pc_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  sel = 2'b00;
    logic        flush = 1'b0;
    logic [31:0] btb_tgt = '0, ex_pc4 = '0, ex_tgt = '0;
    logic        pred = 1'b0, hit = 1'b0, bias = 1'b0;
    logic [7:0]  ghr = '0;
    logic        stall = 1'b0;
    logic        req;
    logic [31:0] addr;
    logic        ack = 1'b0;
    logic [31:0] rdata = '0;
    logic [31:0] if_pc;
    logic [23:0] tag;
    logic [5:0]  btb_idx;
    logic [7:0]  pht_idx;
    logic        fire;
    logic        v_o;
    logic [31:0] instr_o, pc_o, pc4_o;
    logic        pred_o, hit_o, bias_o;
    logic [7:0]  ghr_o;

    always #5 clk = ~clk;

    fetch_pc_unit #(.INDEX_WIDTH(6), .HISTORY_WIDTH(8), .RESET_PC(RST_PC)) dut (
        .clk_i(clk), .rst_ni(rst_n), .IF_PCnext_sel_i(sel), .IF_flush_i(flush),
        .IF_btb_rd_target_i(btb_tgt), .EXMEM_pc_plus4_i(ex_pc4), .EXMEM_br_target_i(ex_tgt),
        .IF_prediction_i(pred), .IF_btb_hit_i(hit), .IF_bias_i(bias), .IF_ghr_data_i(ghr),
        .ID_stall_i(stall), .imem_req_o(req), .imem_addr_o(addr), .imem_ack_i(ack),
        .imem_rdata_i(rdata), .IF_pc_o(if_pc), .IF_PC_tag_o(tag), .IF_btb_rd_index_o(btb_idx),
        .IF_pht_rd_index_o(pht_idx), .IF_fire_o(fire), .IFID_valid_o(v_o),
        .IFID_instr_o(instr_o), .IFID_pc_o(pc_o), .IFID_pc_plus4_o(pc4_o),
        .IFID_prediction_o(pred_o), .IFID_btb_hit_o(hit_o), .IFID_bias_o(bias_o),
        .IFID_ghr_o(ghr_o)
    );

    typedef struct packed {
        logic [31:0] instr, pc, pc4;
        logic        pred, hit, bias;
        logic [7:0]  ghr;
    } rec_t;

    // Reference model: where the fetcher is (waiting, holding a stalled instruction,
    // or throwing away a stale reply), the fetch address, what IF/ID shows.
    localparam int M_WAIT = 0, M_HELD = 1, M_DROP = 2;
    int          m_mode;
    bit          m_init = 0;
    logic [31:0] m_pc;
    bit          m_valid;
    rec_t        m_ifid, m_held;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string tag_s, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag_s, cyc, obs, exp);
        end
    endtask

    function automatic rec_t arriving();
        rec_t r;
        r.instr = rdata; r.pc = m_pc; r.pc4 = m_pc + 32'd4;
        r.pred = pred; r.hit = hit; r.bias = bias; r.ghr = ghr;
        return r;
    endfunction

    function automatic bit model_fire();
        if (!rst_n || flush || stall) return 0;
        return (m_mode == M_WAIT && ack) || (m_mode == M_HELD);
    endfunction

    function automatic logic [31:0] model_dest();
        logic [31:0] d [4];
        d[0] = m_pc + 32'd4; d[1] = ex_pc4; d[2] = btb_tgt; d[3] = ex_tgt;
        return d[sel];
    endfunction

    task automatic model_edge();
        bit f;
        logic [31:0] dest;
        f = model_fire();
        dest = model_dest();
        if (!rst_n) begin
            m_pc = RST_PC; m_mode = M_WAIT; m_valid = 0; m_ifid = '0; m_held = '0; m_init = 1;
        end else if (flush) begin
            m_pc = dest; m_valid = 0; m_held = '0;
            m_mode = (m_mode != M_HELD && !ack) ? M_DROP : M_WAIT;
        end else if (f) begin
            m_ifid = (m_mode == M_HELD) ? m_held : arriving();
            m_valid = 1; m_pc = dest; m_mode = M_WAIT;
        end else begin
            if (!stall) m_valid = 0;
            if (m_mode == M_WAIT && ack) begin
                m_held = arriving(); m_mode = M_HELD;
            end else if (m_mode == M_DROP && ack) begin
                m_mode = M_WAIT;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        if (m_init) begin
            chk("imem_req", {31'd0, req}, {31'd0, rst_n && m_mode == M_WAIT});
            chk("imem_addr", addr, m_pc);
            chk("if_pc", if_pc, m_pc);
            chk("tag", {8'd0, tag}, {8'd0, m_pc[31:8]});
            chk("btb_idx", {26'd0, btb_idx}, {26'd0, m_pc[7:2]});
            chk("pht_idx", {24'd0, pht_idx}, {24'd0, m_pc[9:2]});
            chk("fire", {31'd0, fire}, {31'd0, model_fire()});
        end else begin
            chk("req_in_reset", {31'd0, req}, 32'd0);
        end
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        chk("ifid_valid", {31'd0, v_o}, {31'd0, m_valid});
        chk("ifid_instr", instr_o, m_ifid.instr);
        chk("ifid_pc", pc_o, m_ifid.pc);
        chk("ifid_pc4", pc4_o, m_ifid.pc4);
        chk("ifid_meta", {29'd0, pred_o, hit_o, bias_o}, {29'd0, m_ifid.pred, m_ifid.hit, m_ifid.bias});
        chk("ifid_ghr", {24'd0, ghr_o}, {24'd0, m_ifid.ghr});
    endtask

    task automatic drive(input bit a, input bit s, input bit f, input logic [1:0] sl);
        ack = a; stall = s; flush = f; sel = sl;
        rdata = $urandom; ghr = 8'($urandom);
        pred = 1'($urandom); hit = 1'($urandom); bias = 1'($urandom);
    endtask

    initial begin
        // Reset, then sequential fetch 100, 104 with a BTB hit to 200.
        rst_n = 0; drive(1, 0, 0, 2'b00);
        cycle(); cycle();
        rst_n = 1;
        chk("rst_valid", {31'd0, v_o}, 32'd0);
        chk("rst_ifid_pc", pc_o, 32'd0);
        drive(1, 0, 0, 2'b00); cycle();
        chk("first_ifid_pc", pc_o, 32'h100);
        drive(1, 0, 0, 2'b10); btb_tgt = 32'h200; pred = 1; hit = 1; cycle();
        chk("btb_redirect", addr, 32'h200);
        chk("btb_pred_meta", {31'd0, pred_o}, 32'd1);

        // Stall for three cycles across an ack: instruction at 200 waits in the skid.
        drive(1, 1, 0, 2'b00); ghr = 8'h5A; cycle();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 2'b00); cycle();
            chk("hold_no_req", {31'd0, req}, 32'd0);
        end
        drive(0, 0, 0, 2'b00); cycle();
        chk("hold_release_pc", pc_o, 32'h200);
        chk("hold_release_ghr", {24'd0, ghr_o}, 32'h5A);

        // Flush to 300 while the request at 204 is unacked; the next reply is stale.
        drive(0, 0, 1, 2'b11); ex_tgt = 32'h300; cycle();
        drive(1, 0, 0, 2'b00); rdata = 32'hDEAD_BEEF; cycle();
        chk("drain_valid", {31'd0, v_o}, 32'd0);
        chk("drain_next_pc", addr, 32'h300);

        // Flush coinciding with ack and stall: flush wins, no skid, no IF/ID load.
        drive(1, 1, 1, 2'b01); ex_pc4 = 32'h400; cycle();
        chk("flush_wins_pc", if_pc, 32'h400);
        chk("flush_wins_valid", {31'd0, v_o}, 32'd0);
        chk("flush_wins_req", {31'd0, req}, 32'd1);

        // PC wrap at the top of the address space.
        drive(1, 0, 1, 2'b11); ex_tgt = 32'hFFFF_FFFC; cycle();
        drive(1, 0, 0, 2'b00); cycle();
        chk("wrap_pc", addr, 32'h0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            bit f;
            f = ($urandom_range(0, 9) == 0);
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 9) < 3, f,
                  f ? ($urandom_range(0, 1) ? 2'b11 : 2'b01) : ($urandom_range(0, 1) ? 2'b10 : 2'b00));
            btb_tgt = $urandom & 32'hFFFF_FFFC;
            ex_pc4  = $urandom & 32'hFFFF_FFFC;
            ex_tgt  = $urandom & 32'hFFFF_FFFC;
            rst_n   = ($urandom_range(0, 99) != 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
